decode_stage: RTL
=================

Name: decode_stage

Overview:
- Decode stage of the 5-stage ARM pipeline. Sits directly downstream of fetch and consumes its instruction and PC+4 outputs.
- Extracts instruction fields, reads a 15-entry register file (R0-R14, with R15 synthesised from the PC), and extends the immediate.
- Captures all results in the decode→execute pipeline register.
- Accepts the writeback port from the last stage.

Parameters:
- WIDTH, 32, datapath and register width.
- NREGS, 15, number of architectural registers stored (R0..R14).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clearPipe  input  1  flush: loads a bubble into the execute register.
- pipeEnable  input  1  execute register load enable; 0 = stall (hold).
- instD  input  32  instruction from the fetch/decode pipe register.
- pcPlus8D  input  32  value read for R15; driven by fetch's pcPlus4 output (equals PC_D+8).
- wbEnable  input  1  register-file write enable.
- wbAddr  input  4  register-file write address.
- wbData  input  32  register-file write data.
- rd1E  output  32  operand 1 (Rn, or R15 for branches).
- rd2E  output  32  operand 2 (Rm, or Rd for stores).
- extImmE  output  32  extended immediate.
- ra1E  output  4  source register address 1, used for forwarding.
- ra2E  output  4  source register address 2, used for forwarding.
- rdE  output  4  destination register field, instD[15:12].
- condE  output  4  condition field, instD[31:28].
- opE  output  2  op field, instD[27:26].
- functE  output  6  funct field, instD[25:20].
- validE  output  1  1 = execute register holds a real instruction; 0 = bubble.

Behaviour:
- Address selection (combinational):
  - ra1 = 4'd15 when op==2'b10 (branch); otherwise instD[19:16].
  - ra2 = instD[15:12] when op==2'b01 and instD[20]==0 (store); otherwise instD[3:0].
- Register read (combinational):
  - Address 15 returns pcPlus8D.
  - Any other address returns the stored register, subject to the bypass rule under Optional Feature.
- Register write:
  - Occurs on rising clock edge when wbEnable==1 and wbAddr!=15.
  - wbAddr==15 writes are discarded; PC updates go through the fetch muxes instead.
  - Writes proceed regardless of pipeEnable and clearPipe.
- Immediate extension (combinational, keyed on op):
  - 00: if instD[25]==1, zero-extend instD[7:0] and rotate right by 2*instD[11:8]. A rotation of 0 leaves it unchanged. If instD[25]==0, result is 0.
  - 01: zero-extend instD[11:0].
  - 10: sign-extend instD[23:0], then shift left by 2.
  - 11: 0.
- Execute register (1-cycle latency): priority is reset > clearPipe > pipeEnable.
  - reset (async): R0-R14 and every output set to 0; validE=0.
  - clearPipe==1 at edge: all E outputs set to 0, validE=0. This holds even when pipeEnable==0; the flush wins over the stall.
  - pipeEnable==1 at edge: load all decoded values; validE=1.
  - pipeEnable==0 at edge: hold all E outputs unchanged.
- Reset mid-operation: asynchronous clear takes effect immediately without waiting for a clock edge. The first enabled edge after reset is released captures normally.
- No internal state machine; sequential state = register file + execute pipeline register.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
  - Defined: a read whose address equals wbAddr, with wbEnable==1 and address!=15, returns wbData in the same cycle (write-through). A writeback and a dependent decode in the same cycle therefore need no stall.
  - Undefined: reads return the stored value, i.e. the old value in that cycle. The hazard unit must stall one cycle for this case.

Test Plan:
- Reset: assert reset with registers preloaded → all E outputs 0 and validE=0 immediately. After release, reading R3 gives 0.
- Writeback then read: write R2=0x0000_00AA. Next cycle decode ADD R1,R2,R3 (0xE0821003) with pipeEnable=1. Expected after the edge: rd1E=0xAA, ra1E=2, ra2E=3, rdE=1, opE=0, validE=1.
- Same-cycle bypass: wbEnable=1, wbAddr=4, wbData=0x1234 while decoding a read of R4. Expected rd1E=0x1234 with DECODE_WB_BYPASS_EN defined, old value without it. Write to wbAddr=15 → no register changes.
- Immediates:
  - MOV with imm8=0xFF, rot=4 → extImmE=0xFF000000.
  - LDR with imm12=0xFFF → 0x00000FFF.
  - Branch with imm24=0xFFFFFE, pcPlus8D=0x100 → extImmE=0xFFFFFFF8, rd1E=0x100, ra1E=15.
- Store select: STR R5,[R6] (0xE5865000) → ra2E=5, rd2E=R5 contents.
- Stall/flush: pipeEnable=0 for 2 cycles → E outputs constant. clearPipe=1 together with pipeEnable=0 → all E outputs 0, validE=0.

Source files
------------

// File: rtl/decode_stage.sv
// ARM decode stage: field extraction, 15-entry register file with R15 read as PC+8,
// immediate extension, and the decode->execute register. Optional macro: DECODE_WB_BYPASS_EN.
module decode_stage #(
  parameter int WIDTH = 32,
  parameter int NREGS = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clearPipe,
  input  logic             pipeEnable,
  input  logic [31:0]      instD,
  input  logic [WIDTH-1:0] pcPlus8D,
  input  logic             wbEnable,
  input  logic [3:0]       wbAddr,
  input  logic [WIDTH-1:0] wbData,
  output logic [WIDTH-1:0] rd1E,
  output logic [WIDTH-1:0] rd2E,
  output logic [WIDTH-1:0] extImmE,
  output logic [3:0]       ra1E,
  output logic [3:0]       ra2E,
  output logic [3:0]       rdE,
  output logic [3:0]       condE,
  output logic [1:0]       opE,
  output logic [5:0]       functE,
  output logic             validE
);

  logic [WIDTH-1:0] rf [NREGS];

  logic [1:0]       op_p0;
  logic [3:0]       ra1_p0;
  logic [3:0]       ra2_p0;
  logic [WIDTH-1:0] rd1_p0;
  logic [WIDTH-1:0] rd2_p0;
  logic [WIDTH-1:0] imm_p0;

  // Rotated 8-bit data immediate, 12-bit memory offset, or word-scaled branch offset.
  function automatic logic [WIDTH-1:0] ext_imm(input logic [1:0] op, input logic i_bit,
                                                input logic [23:0] imm24);
    logic [2*WIDTH-1:0]      dbl;
    logic signed [WIDTH-1:0] br;
    logic [WIDTH-1:0]        imm8;
    logic [WIDTH-1:0]        r;
    r    = '0;
    imm8 = WIDTH'(imm24[7:0]);
    case (op)
      2'b00: begin
        if (i_bit) begin
          dbl = {imm8, imm8} >> {imm24[11:8], 1'b0};
          r   = dbl[WIDTH-1:0];
        end
      end
      2'b01: r = WIDTH'(imm24[11:0]);
      2'b10: begin
        br = {{(WIDTH-24){imm24[23]}}, imm24};
        r  = br <<< 2;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op_p0  = instD[27:26];
  assign ra1_p0 = (op_p0 == 2'b10) ? 4'd15 : instD[19:16];
  assign ra2_p0 = (op_p0 == 2'b01 && !instD[20]) ? instD[15:12] : instD[3:0];
  assign imm_p0 = ext_imm(op_p0, instD[25], instD[23:0]);

  always_comb begin
    rd1_p0 = (ra1_p0 == 4'd15) ? pcPlus8D : rf[ra1_p0];
    rd2_p0 = (ra2_p0 == 4'd15) ? pcPlus8D : rf[ra2_p0];
`ifdef DECODE_WB_BYPASS_EN
    if (wbEnable && wbAddr != 4'd15 && wbAddr == ra1_p0) rd1_p0 = wbData;
    if (wbEnable && wbAddr != 4'd15 && wbAddr == ra2_p0) rd2_p0 = wbData;
`endif
  end

  // Register file: PC writes are dropped, fetch owns R15.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wbEnable && wbAddr != 4'd15) begin
      rf[wbAddr] <= wbData;
    end
  end

  // ---- decode -> execute boundary ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset || clearPipe) begin
      rd1E    <= '0;
      rd2E    <= '0;
      extImmE <= '0;
      ra1E    <= '0;
      ra2E    <= '0;
      rdE     <= '0;
      condE   <= '0;
      opE     <= '0;
      functE  <= '0;
      validE  <= 1'b0;
    end else if (pipeEnable) begin
      rd1E    <= rd1_p0;
      rd2E    <= rd2_p0;
      extImmE <= imm_p0;
      ra1E    <= ra1_p0;
      ra2E    <= ra2_p0;
      rdE     <= instD[15:12];
      condE   <= instD[31:28];
      opE     <= op_p0;
      functE  <= instD[25:20];
      validE  <= 1'b1;
    end
  end

endmodule
